// File: rtl/fismos_debug_monitor.sv
// Console capture FIFO, run-status FSM and IRQ edge counters for the FISMOS PicoRV32 debug outputs.
// The host reads characters and end-of-run status directly, with no hierarchical probing.
module fismos_debug_monitor #(
   parameter int          DATA_W     = 8,
   parameter int          DEPTH      = 64,
   parameter logic [31:0] TERM_WORD  = 32'h0000_007E,
   parameter int          TRAP_DRAIN = 10,
   parameter int          TIMEOUT    = 0,
   parameter int          NUM_IRQ    = 1,
   parameter int          CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [31:0]                 out32bit,
   input  logic                        out32bit_en,
   input  logic                        trap,
   input  logic [NUM_IRQ-1:0]          irq_in,
   input  logic                        clear,
   input  logic                        rd_ready,
   output logic                        rd_valid,
   output logic [DATA_W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]      fifo_level,
   output logic                        overflow,
   output logic                        done,
   output logic [1:0]                  done_cause,
   output logic [NUM_IRQ*CNT_W-1:0]    irq_rise_cnt,
   output logic [NUM_IRQ*CNT_W-1:0]    irq_fall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DR_W  = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [DR_W-1:0]  DR_LAST  = DR_W'((TRAP_DRAIN > 0) ? TRAP_DRAIN - 1 : 0);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cause, cause_nxt;
   logic [RUN_W-1:0]  run_cnt, run_cnt_nxt;
   logic [DR_W-1:0]   drn_cnt, drn_cnt_nxt;

   logic              en_prev;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr, rptr;
   logic [LVL_W-1:0]  level;
   logic              ovf;

   logic term_hit, wr, pop, full, wr_ok;

   assign term_hit = (out32bit == TERM_WORD);
   assign full     = (level == LVL_W'(DEPTH));
   assign pop      = (level != '0) && rd_ready;
   assign wr       = (state != S_DONE) && out32bit_en && !en_prev;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
   assign wr_ok    = wr && (!full || pop);

   // Edge detectors survive a soft clear so a held strobe is not re-captured.
   always_ff @(posedge clk) begin
      if (!resetn) en_prev <= 1'b0;
      else         en_prev <= out32bit_en;
   end

   always_ff @(posedge clk) begin
      if (resetn && !clear && wr_ok) mem[wptr] <= out32bit[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + PTR_W'(1);
         if (pop)   rptr <= rptr + PTR_W'(1);
         case ({wr_ok, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (wr && !wr_ok) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         state   <= S_RUN;
         cause   <= 2'd0;
         run_cnt <= '0;
         drn_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cause   <= cause_nxt;
         run_cnt <= run_cnt_nxt;
         drn_cnt <= drn_cnt_nxt;
      end
   end

   // Terminator outranks trap, which outranks the watchdog.
   always_comb begin
      state_nxt   = state;
      cause_nxt   = cause;
      run_cnt_nxt = run_cnt;
      drn_cnt_nxt = drn_cnt;
      case (state)
         S_RUN: begin
            run_cnt_nxt = run_cnt + RUN_W'(1);
            if (term_hit) begin
               state_nxt = S_DONE;
               cause_nxt = 2'd1;
            end else if (trap) begin
               state_nxt   = S_DRAIN;
               drn_cnt_nxt = '0;
            end else if ((TIMEOUT != 0) && (run_cnt == RUN_LAST)) begin
               state_nxt = S_DONE;
               cause_nxt = 2'd3;
            end
         end
         S_DRAIN: begin
            drn_cnt_nxt = drn_cnt + DR_W'(1);
            if (term_hit) begin
               state_nxt = S_DONE;
               cause_nxt = 2'd1;
            end else if (drn_cnt == DR_LAST) begin
               state_nxt = S_DONE;
               cause_nxt = 2'd2;
            end
         end
         default: ;
      endcase
   end

   assign rd_valid   = (level != '0);
   assign rd_data    = rd_valid ? mem[rptr] : '0;
   assign fifo_level = level;
   assign overflow   = ovf;
   assign done       = (state == S_DONE);
   assign done_cause = cause;

   logic [NUM_IRQ-1:0] irq_prev;

   always_ff @(posedge clk) begin
      if (!resetn) irq_prev <= '0;
      else         irq_prev <= irq_in;
   end

   // Per-line saturating edge counters; they keep counting after DONE.
   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
      logic [CNT_W-1:0] rise_q, fall_q;

      always_ff @(posedge clk) begin
         if (!resetn || clear) begin
            rise_q <= '0;
            fall_q <= '0;
         end else begin
            if (irq_in[i] && !irq_prev[i] && (rise_q != '1)) rise_q <= rise_q + CNT_W'(1);
            if (!irq_in[i] && irq_prev[i] && (fall_q != '1)) fall_q <= fall_q + CNT_W'(1);
         end
      end

      assign irq_rise_cnt[i*CNT_W +: CNT_W] = rise_q;
      assign irq_fall_cnt[i*CNT_W +: CNT_W] = fall_q;
   end

endmodule

// File: tb/tb_fismos_debug_monitor.sv
// Scoreboard bench: a cycle-level reference model predicts status and queues expected characters;
// a negedge monitor compares every output and pops the queue on each host read.
module tb_fismos_debug_monitor;

   localparam int          DATA_W     = 8;
   localparam int          DEPTH      = 4;
   localparam logic [31:0] TERM       = 32'h0000_007E;
   localparam int          TRAP_DRAIN = 10;
   localparam int          TIMEOUT    = 100;
   localparam int          NUM_IRQ    = 2;
   localparam int          CNT_W      = 2;
   localparam int          SAT        = (1 << CNT_W) - 1;

   logic                     clk = 1'b0;
   logic                     resetn = 1'b0;
   logic [31:0]              out32bit = '0;
   logic                     out32bit_en = 1'b0;
   logic                     trap = 1'b0;
   logic [NUM_IRQ-1:0]       irq_in = '0;
   logic                     clear = 1'b0;
   logic                     rd_ready = 1'b0;
   logic                     rd_valid;
   logic [DATA_W-1:0]        rd_data;
   logic [$clog2(DEPTH):0]   fifo_level;
   logic                     overflow;
   logic                     done;
   logic [1:0]               done_cause;
   logic [NUM_IRQ*CNT_W-1:0] irq_rise_cnt;
   logic [NUM_IRQ*CNT_W-1:0] irq_fall_cnt;

   fismos_debug_monitor #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .TERM_WORD(TERM), .TRAP_DRAIN(TRAP_DRAIN),
      .TIMEOUT(TIMEOUT), .NUM_IRQ(NUM_IRQ), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .resetn(resetn), .out32bit(out32bit), .out32bit_en(out32bit_en),
      .trap(trap), .irq_in(irq_in), .clear(clear), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
      .overflow(overflow), .done(done), .done_cause(done_cause),
      .irq_rise_cnt(irq_rise_cnt), .irq_fall_cnt(irq_fall_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: run status as flags plus elapsed-cycle counts, FIFO as a count and a queue.
   bit                m_done, m_drain, m_ovf, m_en_prev;
   int                m_cause, m_level, m_run, m_dcyc;
   bit [NUM_IRQ-1:0]  m_irq_prev;
   int                m_rise[NUM_IRQ];
   int                m_fall[NUM_IRQ];
   logic [DATA_W-1:0] sb_q[$];

   task automatic model_clear();
      m_done = 0; m_drain = 0; m_ovf = 0;
      m_cause = 0; m_level = 0; m_run = 0; m_dcyc = 0;
      sb_q.delete();
      for (int i = 0; i < NUM_IRQ; i++) begin
         m_rise[i] = 0;
         m_fall[i] = 0;
      end
   endtask

   task automatic finish_run(input int c);
      m_done = 1;
      m_drain = 0;
      m_cause = c;
   endtask

   task automatic model_step();
      bit pop;
      if (!resetn) begin
         model_clear();
         m_en_prev = 0;
         m_irq_prev = '0;
         return;
      end
      if (clear) model_clear();
      else begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_in[i] && !m_irq_prev[i] && m_rise[i] < SAT) m_rise[i]++;
            if (!irq_in[i] && m_irq_prev[i] && m_fall[i] < SAT) m_fall[i]++;
         end
         pop = rd_ready && (m_level > 0);
         if (!m_done && out32bit_en && !m_en_prev) begin
            if (m_level == DEPTH && !pop) m_ovf = 1;
            else begin
               sb_q.push_back(out32bit[DATA_W-1:0]);
               m_level++;
            end
         end
         if (pop) m_level--;
         if (!m_done) begin
            if (out32bit == TERM) finish_run(1);
            else if (m_drain) begin
               m_dcyc++;
               if (m_dcyc == TRAP_DRAIN) finish_run(2);
            end else if (trap) begin
               m_drain = 1;
               m_dcyc = 0;
            end else begin
               m_run++;
               if (m_run == TIMEOUT) finish_run(3);
            end
         end
      end
      m_en_prev  = out32bit_en;
      m_irq_prev = irq_in;
   endtask

   // Every clock goes through here so the model sees exactly the inputs the DUT sampled.
   task automatic drive(input logic [31:0] o, input logic en, input logic tr, input logic rd,
                        input logic clr, input logic [NUM_IRQ-1:0] irq, input logic rn);
      @(posedge clk);
      model_step();
      #1;
      out32bit = o; out32bit_en = en; trap = tr; rd_ready = rd;
      clear = clr; irq_in = irq; resetn = rn;
   endtask

   task automatic idle(input logic rd);
      drive(32'h0, 1'b0, 1'b0, rd, 1'b0, irq_in, 1'b1);
   endtask

   task automatic strobe(input logic [31:0] ch, input logic rd);
      drive(ch, 1'b1, 1'b0, rd, 1'b0, irq_in, 1'b1);
      drive(ch, 1'b0, 1'b0, rd, 1'b0, irq_in, 1'b1);
   endtask

   task automatic do_clear();
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, irq_in, 1'b1);
      idle(1'b0);
   endtask

   // Monitor: compares every output against the model and the read data against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         chk("rd_valid", rd_valid, m_level != 0);
         chk("fifo_level", fifo_level, m_level);
         chk("overflow", overflow, m_ovf);
         chk("done", done, m_done);
         chk("done_cause", done_cause, m_cause);
         for (int i = 0; i < NUM_IRQ; i++) begin
            chk("irq_rise", irq_rise_cnt[i*CNT_W +: CNT_W], m_rise[i]);
            chk("irq_fall", irq_fall_cnt[i*CNT_W +: CNT_W], m_fall[i]);
         end
         if (rd_valid && rd_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_data: got %0h with nothing expected at %0t", rd_data, $time);
            end else chk("rd_data", rd_data, sb_q.pop_front());
         end else if (!rd_valid) chk("rd_data_empty", rd_data, 0);
      end
   end

   initial begin
      int first;
      int p_term, p_trap, p_en, p_rd;
      logic [31:0] o;

      repeat (3) drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      chk("reset_level", fifo_level, 0);
      chk("reset_done", done, 0);

      // 'H','i' then read back
      strobe(32'h48, 1'b0);
      strobe(32'h69, 1'b0);
      @(negedge clk);
      chk("hi_level", fifo_level, 2);
      chk("hi_head", rd_data, 8'h48);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      @(negedge clk);
      chk("hi_empty", rd_valid, 0);

      // terminator captured and ends the run; later strobes dropped
      do_clear();
      strobe(TERM, 1'b0);
      @(negedge clk);
      chk("term_done", done, 1);
      chk("term_cause", done_cause, 1);
      strobe(32'h41, 1'b0);
      @(negedge clk);
      chk("term_level", fifo_level, 1);
      idle(1'b1);
      idle(1'b0);

      // trap drain with a capture mid-drain
      do_clear();
      drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, irq_in, 1'b1);
      first = -1;
      for (int k = 1; k <= 14; k++) begin
         drive((k == 5) ? 32'h53 : 32'h0, k == 5, 1'b0, 1'b0, 1'b0, irq_in, 1'b1);
         @(negedge clk);
         if (done && first < 0) first = k;
      end
      chk("trap_delay", first - 1, TRAP_DRAIN);
      chk("trap_cause", done_cause, 2);
      chk("trap_capture", fifo_level, 1);

      // overflow, then pop+write while full across the pointer wrap
      do_clear();
      for (int k = 0; k < 5; k++) strobe(32'h41 + k, 1'b0);
      @(negedge clk);
      chk("ovf_level", fifo_level, DEPTH);
      chk("ovf_flag", overflow, 1);
      drive(32'h46, 1'b1, 1'b0, 1'b1, 1'b0, irq_in, 1'b1);
      drive(32'h46, 1'b0, 1'b0, 1'b0, 1'b0, irq_in, 1'b1);
      @(negedge clk);
      chk("wrap_level", fifo_level, DEPTH);
      repeat (5) idle(1'b1);
      idle(1'b0);

      // IRQ edges on line 1 only, then saturation
      do_clear();
      for (int k = 0; k < 3; k++) begin
         drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
         drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      end
      idle(1'b0);
      @(negedge clk);
      chk("irq1_rise", irq_rise_cnt[CNT_W +: CNT_W], 3);
      chk("irq1_fall", irq_fall_cnt[CNT_W +: CNT_W], 3);
      chk("irq0_rise", irq_rise_cnt[0 +: CNT_W], 0);
      for (int k = 0; k < 2; k++) begin
         drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
         drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      end
      idle(1'b0);
      @(negedge clk);
      chk("irq1_sat", irq_rise_cnt[CNT_W +: CNT_W], 3);

      // watchdog
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, irq_in, 1'b1);
      repeat (TIMEOUT) idle(1'b0);
      @(negedge clk);
      chk("wd_not_yet", done, 0);
      idle(1'b0);
      @(negedge clk);
      chk("wd_done", done, 1);
      chk("wd_cause", done_cause, 3);

      // clear, then terminator and trap together
      do_clear();
      @(negedge clk);
      chk("clr_done", done, 0);
      drive(TERM, 1'b0, 1'b1, 1'b0, 1'b0, irq_in, 1'b1);
      idle(1'b0);
      @(negedge clk);
      chk("prio_cause", done_cause, 1);

      // randomized phases
      for (int ph = 0; ph < 24; ph++) begin
         p_term = (ph % 3 == 0) ? 2 : 0;
         p_trap = (ph % 4 == 1) ? 3 : 0;
         p_en   = $urandom_range(20, 70);
         p_rd   = (ph % 5 == 2) ? 0 : $urandom_range(10, 80);
         if (ph % 8 == 7) drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, irq_in, 1'b0);
         else drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, irq_in, 1'b1);
         for (int c = 0; c < ((ph % 6 == 5) ? 130 : 60); c++) begin
            if ($urandom_range(0, 99) < p_term) o = TERM;
            else if ($urandom_range(0, 99) < 5) o = $urandom;
            else o = {24'h0, 8'($urandom)};
            drive(o, $urandom_range(0, 99) < p_en, $urandom_range(0, 99) < p_trap,
                  $urandom_range(0, 99) < p_rd, $urandom_range(0, 99) < 1,
                  NUM_IRQ'($urandom), 1'b1);
         end
      end
      repeat (3) idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fismos_debug_monitor.md
Name: fismos_debug_monitor

Overview:
Synthesizable capture/monitor for the FISMOS PicoRV32 debug outputs. It captures characters from the out32bit/out32bit_en console stream into a FIFO and detects end of program (terminator character), trap (with drain delay) and watchdog timeout. It also counts edges on a configurable number of interrupt lines. It sits beside the fismos top so a host or bench can read console output and run status without hierarchical probing.

Parameters:
DATA_W, 8, captured character width (out32bit[DATA_W-1:0]); 1..32
DEPTH, 64, FIFO entries; power of 2, >=2
TERM_WORD, 32'h0000_007E, full 32-bit out32bit value that marks end of main()
TRAP_DRAIN, 10, cycles between trap detection and DONE
TIMEOUT, 0, watchdog cycles in RUN; 0 disables it
NUM_IRQ, 1, interrupt lines monitored
CNT_W, 16, width of each edge counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
out32bit  in  32  console word from core
out32bit_en  in  1  console strobe; capture on its rising edge
trap  in  1  core trap
irq_in  in  NUM_IRQ  monitored interrupt lines (e.g. interrupt_to_linux)
clear  in  1  synchronous soft restart
rd_ready  in  1  host pop request
rd_valid  out  1  FIFO non-empty
rd_data  out  DATA_W  FIFO head (first-word fall-through)
fifo_level  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: a write was dropped
done  out  1  FSM in DONE
done_cause  out  2  0 none, 1 terminator, 2 trap, 3 timeout
irq_rise_cnt  out  NUM_IRQ*CNT_W  per-line rising-edge counts, line i at [i*CNT_W +: CNT_W]
irq_fall_cnt  out  NUM_IRQ*CNT_W  per-line falling-edge counts

Behaviour:
- Reset (resetn=0 at posedge): FSM=RUN, FIFO empty, fifo_level=0, rd_valid=0, rd_data=0, overflow=0, done=0, done_cause=0, all counters 0, en_prev=0, irq_prev=0, drain/timeout counters 0.
- clear=1 has the same effect as reset, except that it does not reset en_prev or irq_prev. Reset has priority over clear.
- Capture: wr = (state!=DONE) && out32bit_en && !en_prev. The FIFO is written at that posedge with out32bit[DATA_W-1:0]. rd_valid and fifo_level update on the next cycle (1-cycle latency).
- Pop: rd_valid && rd_ready advances the head. rd_data always shows the head. Pops are allowed in every state.
- Full FIFO: a wr with no pop is dropped and overflow is set (sticky until reset/clear). A wr with a pop in the same cycle is accepted and the level is unchanged. Empty FIFO: rd_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_level never exceeds DEPTH.
- FSM states and transitions:
  - RUN:
    - out32bit==TERM_WORD (level, any cycle, strobe not required) -> DONE, cause=1.
    - Else trap=1 -> DRAIN, drain counter=0.
    - Else TIMEOUT!=0 and the run counter reaches TIMEOUT-1 -> DONE, cause=3.
    - The run counter increments every RUN cycle.
  - DRAIN: the counter increments each cycle. At TRAP_DRAIN-1 -> DONE, cause=2. Terminator seen during DRAIN -> DONE, cause=1 immediately. Capture continues during DRAIN.
  - DONE: holds until reset/clear. done=1. No further captures.
- Priority within the same cycle: terminator > trap > timeout. A strobe edge in the same cycle as the terminator is still captured.
- IRQ counters: a rise on line i is irq_in[i] && !irq_prev[i]; a fall is the inverse. Counters saturate at 2^CNT_W-1. Counting continues in all states, including DONE.
- All outputs are registered except rd_valid, rd_data and done, which are decoded from registers.

Test Plan:
- Console capture: pulse out32bit_en with 'H','i' (0x48, 0x69) one cycle each -> fifo_level=2; pop with rd_ready -> rd_data 0x48 then 0x69, rd_valid=0 after.
- Terminator: drive out32bit=0x0000007E with en=1 -> char 0x7E captured, done=1, done_cause=1 next cycle; later strobes are not captured.
- Trap drain: trap=1 for 1 cycle with TRAP_DRAIN=10 -> done asserts exactly 10 cycles after the DRAIN entry, cause=2; a strobe at drain cycle 5 is captured.
- Overflow/wrap: DEPTH=4, 5 strobes with no pop -> level=4, overflow=1, contents are the first 4 chars. Then pop and write in the same cycle -> level stays 4 and the order is preserved across the pointer wrap.
- IRQ edges: NUM_IRQ=2, toggle line1 high/low 3 times, line0 idle -> irq_rise_cnt line1=3, fall=3, line0=0. CNT_W=2 with 5 rises -> saturates at 3.
- Timeout/clear: TIMEOUT=100, no events -> done at cycle 100, cause=3. Then clear=1 -> RUN, counters 0, overflow 0; a simultaneous terminator and trap give cause=1.
